// File: rtl/saph_raster_stepper.sv
// Row-major scan controller driving the row/pixel float incrementers; start to first out_valid is 3 cycles.
// out_valid holds with stable coordinates until out_ready; no count pulse is issued while stalled or awaiting a ready.
module saph_raster_stepper #(
  parameter int coord_width = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  output logic                   busy,
  output logic                   done,
  input  logic [coord_width-1:0] x0,
  input  logic [coord_width-1:0] y0,
  input  logic [coord_width-1:0] width,
  input  logic [coord_width-1:0] height,
  output logic                   row_latch,
  output logic                   row_count,
  input  logic                   row_ready,
  output logic                   px_latch,
  output logic                   px_count,
  input  logic                   px_ready,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [coord_width-1:0] out_x,
  output logic [coord_width-1:0] out_y,
  output logic                   out_last
);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] INIT  = 3'd1;
  localparam logic [2:0] ROW   = 3'd2;
  localparam logic [2:0] EMIT  = 3'd3;
  localparam logic [2:0] PWAIT = 3'd4;
  localparam logic [2:0] RWAIT = 3'd5;

  localparam logic [coord_width-1:0] ONE = {{(coord_width-1){1'b0}}, 1'b1};

  logic [2:0]             state;
  logic [coord_width-1:0] x0_q, y0_q, w_q, h_q;
  logic [coord_width-1:0] col, row;
  logic                   done_q;
  logic                   col_last, row_last, accept;

  // Compare against width-1 rather than col+1 so a full-range width cannot overflow.
  assign col_last = (col == w_q - ONE);
  assign row_last = (row == h_q - ONE);
  assign accept   = (state == EMIT) && out_ready;

  assign busy      = (state != IDLE);
  assign done      = done_q;
  assign row_latch = (state == INIT);
  assign px_latch  = (state == ROW);
  assign out_valid = (state == EMIT);
  assign px_count  = accept && !col_last;
  assign row_count = accept && col_last && !row_last;
  assign out_last  = out_valid && col_last && row_last;
  assign out_x     = x0_q + col;
  assign out_y     = y0_q + row;

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      x0_q   <= '0;
      y0_q   <= '0;
      w_q    <= '0;
      h_q    <= '0;
      col    <= '0;
      row    <= '0;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            if (width != '0 && height != '0) begin
              x0_q  <= x0;
              y0_q  <= y0;
              w_q   <= width;
              h_q   <= height;
              col   <= '0;
              row   <= '0;
              state <= INIT;
            end else begin
              done_q <= 1'b1;
            end
          end
        end
        INIT: state <= ROW;
        ROW:  state <= EMIT;
        EMIT: begin
          if (out_ready) begin
            if (!col_last) begin
              col   <= col + ONE;
              state <= PWAIT;
            end else if (!row_last) begin
              col   <= '0;
              row   <= row + ONE;
              state <= RWAIT;
            end else begin
              state  <= IDLE;
              done_q <= 1'b1;
            end
          end
        end
        PWAIT: if (px_ready) state <= EMIT;
        RWAIT: if (row_ready) state <= ROW;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_saph_raster_stepper.sv
// Directed bench for saph_raster_stepper with a latency-2 incrementer model on both ready inputs.
module tb_saph_raster_stepper;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        busy, done;
  logic [15:0] x0 = '0, y0 = '0, width = '0, height = '0;
  logic        row_latch, row_count, row_ready;
  logic        px_latch, px_count, px_ready;
  logic        out_valid, out_ready = 1'b0, out_last;
  logic [15:0] out_x, out_y;

  logic [1:0]  pc_sh = '0, rc_sh = '0;
  logic        stray_px = 1'b0;
  int          n_rl = 0, n_pl = 0, n_pc = 0, n_rc = 0, n_done = 0, n_multi = 0;
  logic [32:0] px_q[$];
  int          n_assert = 0, n_fail = 0;

  saph_raster_stepper #(.coord_width(16)) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
    .x0(x0), .y0(y0), .width(width), .height(height),
    .row_latch(row_latch), .row_count(row_count), .row_ready(row_ready),
    .px_latch(px_latch), .px_count(px_count), .px_ready(px_ready),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_x(out_x), .out_y(out_y), .out_last(out_last)
  );

  always #5 clk = ~clk;

  // Incrementer model: ready pulses two cycles after the count pulse.
  assign px_ready  = pc_sh[1] | stray_px;
  assign row_ready = rc_sh[1];

  always @(posedge clk) begin
    pc_sh <= {pc_sh[0], px_count};
    rc_sh <= {rc_sh[0], row_count};
    if (row_latch) n_rl++;
    if (px_latch)  n_pl++;
    if (px_count)  n_pc++;
    if (row_count) n_rc++;
    if (done)      n_done++;
    if ($countones({row_latch, px_latch, row_count, px_count}) > 1) n_multi++;
    if (out_valid && out_ready) px_q.push_back({out_last, out_x, out_y});
  end

  task automatic chk(input string tag, input logic [47:0] obs, input logic [47:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_start(input logic [15:0] x, input logic [15:0] y,
                          input logic [15:0] w, input logic [15:0] h);
    x0 = x; y0 = y; width = w; height = h; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int k;
    k = 0;
    while (!done && k < 300) begin @(negedge clk); k++; end
    chk(tag, 48'(k < 300), 48'd1);
  endtask

  task automatic wait_valid(input string tag);
    int k;
    k = 0;
    while (!out_valid && k < 300) begin @(negedge clk); k++; end
    chk(tag, 48'(k < 300), 48'd1);
  endtask

  task automatic chk_px(input string tag, input int idx, input logic last,
                        input logic [15:0] x, input logic [15:0] y);
    if (idx < px_q.size()) chk(tag, 48'(px_q[idx]), 48'({last, x, y}));
    else chk({tag, "_missing"}, 48'(px_q.size()), 48'(idx + 1));
  endtask

  initial begin
    int b, brl, bpl, bpc, brc, bdone, k;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_ctrl", 48'({busy, done, out_valid, out_last, row_latch, row_count, px_latch, px_count}), 48'd0);
    chk("rst_xy", 48'({out_x, out_y}), 48'd0);
    rst = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);

    // 1x1 cycle-exact latency
    x0 = 16'd3; y0 = 16'd4; width = 16'd1; height = 16'd1; start = 1'b1;
    @(negedge clk); start = 1'b0;
    chk("c1_row_latch", 48'({busy, row_latch, px_latch, out_valid}), 48'b1100);
    @(negedge clk);
    chk("c2_px_latch", 48'({busy, row_latch, px_latch, out_valid}), 48'b1010);
    @(negedge clk);
    chk("c3_valid", 48'({out_valid, out_last, px_count, row_count}), 48'b1100);
    chk("c3_xy", 48'({out_x, out_y}), 48'h0003_0004);
    @(negedge clk);
    chk("c4_done", 48'({done, busy}), 48'b10);
    @(negedge clk);

    // Basic 2x2
    b = px_q.size(); brl = n_rl; bpl = n_pl; bpc = n_pc; brc = n_rc; bdone = n_done;
    do_start(16'd10, 16'd20, 16'd2, 16'd2);
    wait_done("b2x2_timeout");
    @(negedge clk);
    chk("b2x2_npix", 48'(px_q.size() - b), 48'd4);
    chk_px("b2x2_p0", b + 0, 1'b0, 16'd10, 16'd20);
    chk_px("b2x2_p1", b + 1, 1'b0, 16'd11, 16'd20);
    chk_px("b2x2_p2", b + 2, 1'b0, 16'd10, 16'd21);
    chk_px("b2x2_p3", b + 3, 1'b1, 16'd11, 16'd21);
    chk("b2x2_pulses", 48'({8'(n_rl - brl), 8'(n_pl - bpl), 8'(n_pc - bpc), 8'(n_rc - brc), 8'(n_done - bdone)}),
        48'h01_02_02_01_01);

    // Empty rectangle
    b = px_q.size(); brl = n_rl; bpl = n_pl; bpc = n_pc; brc = n_rc; bdone = n_done;
    do_start(16'd1, 16'd1, 16'd0, 16'd5);
    chk("empty_done", 48'({done, busy}), 48'b10);
    repeat (3) @(negedge clk);
    chk("empty_idle", 48'({busy, out_valid, done}), 48'd0);
    chk("empty_activity", 48'({8'(n_rl - brl), 8'(n_pl - bpl), 8'(n_pc - bpc), 8'(n_rc - brc), 8'(px_q.size() - b)}), 48'd0);
    chk("empty_ndone", 48'(n_done - bdone), 48'd1);

    // Backpressure on the second pixel of a 3x1 scan
    b = px_q.size();
    out_ready = 1'b0;
    do_start(16'd5, 16'd7, 16'd3, 16'd1);
    wait_valid("bp_first_timeout");
    chk("bp_first_x", 48'(out_x), 48'd5);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("bp_pwait", 48'(out_valid), 48'd0);
    wait_valid("bp_second_timeout");
    bpc = n_pc;
    for (int i = 0; i < 4; i++) begin
      chk("bp_hold", 48'({out_valid, px_count, out_x, out_y}), 48'({1'b1, 1'b0, 16'd6, 16'd7}));
      @(negedge clk);
    end
    chk("bp_no_count", 48'(n_pc - bpc), 48'd0);
    out_ready = 1'b1;
    wait_done("bp_done_timeout");
    @(negedge clk);
    chk("bp_npix", 48'(px_q.size() - b), 48'd3);
    chk_px("bp_p0", b + 0, 1'b0, 16'd5, 16'd7);
    chk_px("bp_p1", b + 1, 1'b0, 16'd6, 16'd7);
    chk_px("bp_p2", b + 2, 1'b1, 16'd7, 16'd7);

    // Coordinate wrap-around
    b = px_q.size();
    do_start(16'hFFFF, 16'hFFFF, 16'd2, 16'd2);
    wait_done("wrap_timeout");
    @(negedge clk);
    chk_px("wrap_p0", b + 0, 1'b0, 16'hFFFF, 16'hFFFF);
    chk_px("wrap_p1", b + 1, 1'b0, 16'h0000, 16'hFFFF);
    chk_px("wrap_p2", b + 2, 1'b0, 16'hFFFF, 16'h0000);
    chk_px("wrap_p3", b + 3, 1'b1, 16'h0000, 16'h0000);

    // Reset during PWAIT of a 4x4 scan
    do_start(16'd0, 16'd0, 16'd4, 16'd4);
    k = 0;
    while (!px_count && k < 300) begin @(negedge clk); k++; end
    chk("mid_count_timeout", 48'(k < 300), 48'd1);
    @(negedge clk);
    chk("mid_in_pwait", 48'({busy, out_valid}), 48'b10);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mid_rst_ctrl", 48'({busy, done, out_valid, out_last, row_latch, row_count, px_latch, px_count}), 48'd0);
    chk("mid_rst_xy", 48'({out_x, out_y}), 48'd0);
    repeat (3) @(negedge clk);
    chk("mid_late_ready", 48'({busy, out_valid}), 48'd0);
    b = px_q.size();
    do_start(16'd2, 16'd3, 16'd4, 16'd4);
    wait_done("fresh_timeout");
    @(negedge clk);
    chk("fresh_npix", 48'(px_q.size() - b), 48'd16);
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        chk_px("fresh_px", b + r * 4 + c, (r == 3 && c == 3), 16'(2 + c), 16'(3 + r));

    // Start while busy and stray px_ready in EMIT
    b = px_q.size(); brl = n_rl; bpl = n_pl; bpc = n_pc; brc = n_rc; bdone = n_done;
    out_ready = 1'b0;
    do_start(16'd1, 16'd1, 16'd2, 16'd2);
    wait_valid("stray_valid_timeout");
    x0 = 16'd9; y0 = 16'd9; width = 16'd3; height = 16'd3;
    start = 1'b1; stray_px = 1'b1;
    @(negedge clk);
    start = 1'b0; stray_px = 1'b0;
    chk("stray_still_emit", 48'({busy, out_valid, out_x, out_y}), 48'({1'b1, 1'b1, 16'd1, 16'd1}));
    out_ready = 1'b1;
    wait_done("stray_done_timeout");
    repeat (4) @(negedge clk);
    chk("stray_idle", 48'(busy), 48'd0);
    chk("stray_npix", 48'(px_q.size() - b), 48'd4);
    chk_px("stray_p3", b + 3, 1'b1, 16'd2, 16'd2);
    chk("stray_pulses", 48'({8'(n_rl - brl), 8'(n_pl - bpl), 8'(n_pc - bpc), 8'(n_rc - brc), 8'(n_done - bdone)}),
        48'h01_02_02_01_01);

    chk("pulse_exclusive", 48'(n_multi), 48'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
